// File: rtl/mem_arbiter.sv
// Sole master of the shared pipelined main memory: arbitrates I-fill, D-fill and D write-through,
// runs each fill as a non-preemptible burst and steers tagged return words to the granted cache.
module mem_arbiter #(
    parameter int unsigned MEM_LAT   = 4,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [15:0]       mem_data_in,
    input  logic [15:0]       mem_data_out,
    input  logic              mem_data_valid,
    output logic [15:0]       rd_data,
    output logic [2:0]        rd_word,
    output logic              i_valid,
    output logic              d_valid,
    output logic              i_done,
    output logic              d_done,
    output logic              wr_ack,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StWrite, StIssue, StDrain} state_e;

    localparam logic [2:0] LastWord = 3'(BURST_LEN - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-5:0]   base_q;
    logic [2:0]          iss_cnt_q, ret_cnt_q;
    logic                fill_i_q, last_data_q;
    logic [15:0]         rd_data_q;
    logic [2:0]          rd_word_q;
    logic                i_valid_q, d_valid_q, i_done_q, d_done_q;
    logic                take_i, take_d, take_wr;
    logic                ret_en;

    // Low address bits select a byte within the block and are never used for fills.
    logic unused_bits;
    assign unused_bits = ^{i_addr[3:0], d_addr[3:0]} ^ (MEM_LAT == 0);

    always_comb begin
        state_d     = state_q;
        take_i      = 1'b0;
        take_d      = 1'b0;
        take_wr     = 1'b0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        wr_ack      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // D-class wins unless I is also waiting and D-class had the previous grant.
                if ((wr_req || d_req) && !(i_req && last_data_q)) begin
                    if (wr_req) begin
                        take_wr = 1'b1;
                        state_d = StWrite;
                    end else begin
                        take_d  = 1'b1;
                        state_d = StIssue;
                    end
                end else if (i_req) begin
                    take_i  = 1'b1;
                    state_d = StIssue;
                end
            end
            StWrite: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = wr_addr;
                mem_data_in = wr_data;
                wr_ack      = 1'b1;
                state_d     = StIdle;
            end
            StIssue: begin
                mem_enable = 1'b1;
                mem_addr   = {base_q, iss_cnt_q, 1'b0};
                if (iss_cnt_q == LastWord) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave in the cycle that presents the final word so IDLE follows done.
                if (i_done_q || d_done_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ret_en = mem_data_valid && (state_q == StIssue || state_q == StDrain);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            iss_cnt_q   <= '0;
            ret_cnt_q   <= '0;
            fill_i_q    <= 1'b0;
            last_data_q <= 1'b0;
            rd_data_q   <= '0;
            rd_word_q   <= '0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            if (take_i || take_d || take_wr) begin
                last_data_q <= ~take_i;
            end
            if (take_i || take_d) begin
                base_q    <= take_i ? i_addr[ADDR_W-1:4] : d_addr[ADDR_W-1:4];
                fill_i_q  <= take_i;
                iss_cnt_q <= '0;
                ret_cnt_q <= '0;
            end
            if (state_q == StIssue) begin
                iss_cnt_q <= iss_cnt_q + 3'd1;
            end
            if (ret_en) begin
                rd_data_q <= mem_data_out;
                rd_word_q <= ret_cnt_q;
                ret_cnt_q <= ret_cnt_q + 3'd1;
                i_valid_q <= fill_i_q;
                d_valid_q <= ~fill_i_q;
                if (ret_cnt_q == LastWord) begin
                    i_done_q <= fill_i_q;
                    d_done_q <= ~fill_i_q;
                end
            end
        end
    end

    assign rd_data = rd_data_q;
    assign rd_word = rd_word_q;
    assign i_valid = i_valid_q;
    assign d_valid = d_valid_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign busy    = (state_q != StIdle);

endmodule
